neighbor_gen: RTL

//  Upstream stage of the open-list search in the A* engine. For the node being expanded,

---
 rtl/astar_pkg.sv | 66 ++++++
 rtl/nb_dir_decode.sv | 21 ++
 rtl/neighbor_gen.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/astar_pkg.sv
// Shared A* engine definitions: grid geometry, coordinate/cost types,
// step costs, direction encoding with dx/dy table, FSM state encoding,
// and a saturating cost adder.
package astar_pkg;

  localparam int GRID_W    = 20;
  localparam int GRID_H    = 20;
  localparam int COORD_W   = 8;
  localparam int ADDR_W    = 9;
  localparam int G_W       = 16;
  localparam int COST_ORTH = 10;
  localparam int COST_DIAG = 14;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [G_W-1:0]     cost_t;
  typedef logic [ADDR_W-1:0]  addr_t;

  // Orthogonal directions occupy 0..3 so their index doubles as a wall-history slot
  typedef enum logic [2:0] {
    DIR_N  = 3'd0,
    DIR_E  = 3'd1,
    DIR_S  = 3'd2,
    DIR_W  = 3'd3,
    DIR_NE = 3'd4,
    DIR_SE = 3'd5,
    DIR_SW = 3'd6,
    DIR_NW = 3'd7
  } dir_t;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SELECT    = 3'd1,
    ST_WALL_WAIT = 3'd2,
    ST_WALL_CHK  = 3'd3,
    ST_EMIT      = 3'd4,
    ST_NEXT      = 3'd5,
    ST_DONE      = 3'd6
  } state_t;

  // x offset as 2-bit two's complement: 01 = +1, 11 = -1, 00 = 0
  function automatic logic [1:0] dir_dx(input dir_t d);
    case (d)
      DIR_E, DIR_NE, DIR_SE: return 2'b01;
      DIR_W, DIR_SW, DIR_NW: return 2'b11;
      default:               return 2'b00;
    endcase
  endfunction

  // y offset as 2-bit two's complement; north is toward y = 0
  function automatic logic [1:0] dir_dy(input dir_t d);
    case (d)
      DIR_N, DIR_NE, DIR_NW: return 2'b11;
      DIR_S, DIR_SE, DIR_SW: return 2'b01;
      default:               return 2'b00;
    endcase
  endfunction

  // Cost addition that clamps at all-ones instead of wrapping
  function automatic cost_t sat_add(input cost_t a, input cost_t b);
    logic [G_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum[G_W]) return {G_W{1'b1}};
    else          return sum[G_W-1:0];
  endfunction

endpackage

// File: rtl/nb_dir_decode.sv
// Combinational direction decode: dir -> (dx, dy, step cost, diagonal flag).
module nb_dir_decode
  import astar_pkg::*;
(
  input  logic [2:0]     dir,
  output logic [1:0]     dx,
  output logic [1:0]     dy,
  output logic [G_W-1:0] cost,
  output logic           diag
);

  // Table lookup of offsets and cost for the current direction
  always_comb begin
    dx   = dir_dx(dir_t'(dir));
    dy   = dir_dy(dir_t'(dir));
    diag = dir[2];
    if (dir[2]) cost = cost_t'(COST_DIAG);
    else        cost = cost_t'(COST_ORTH);
  end

endmodule

// File: rtl/neighbor_gen.sv
// Neighbour generator for the A* engine: walks the directions around the
// node being expanded, drops out-of-bounds and walled cells, and emits each
// survivor over a valid/ready handshake.
// Optional macro DIAGONAL_EN: adds NE/SE/SW/NW with no corner cutting.
module neighbor_gen
  import astar_pkg::*;
(
  input  logic               Clk,
  input  logic               Reset,
  input  logic               start,
  input  logic [COORD_W-1:0] cur_x,
  input  logic [COORD_W-1:0] cur_y,
  input  logic [G_W-1:0]     cur_g,
  output logic               wall_rd_en,
  output logic [ADDR_W-1:0]  wall_addr,
  input  logic               wall_rd_data,
  output logic               nb_valid,
  input  logic               nb_ready,
  output logic [COORD_W-1:0] nb_x,
  output logic [COORD_W-1:0] nb_y,
  output logic [G_W-1:0]     nb_g,
  output logic               busy,
  output logic               done,
  output logic [3:0]         nb_count
);

`ifdef DIAGONAL_EN
  localparam dir_t LAST_DIR = DIR_NW;
`else
  localparam dir_t LAST_DIR = DIR_W;
`endif

  state_t state_r;
  dir_t   dir_r;
  coord_t cur_x_r;
  coord_t cur_y_r;
  cost_t  cur_g_r;

  logic [1:0] dx_s;
  logic [1:0] dy_s;
  cost_t      cost_s;
  logic       diag_s;
  coord_t     cand_x_s;
  coord_t     cand_y_s;
  addr_t      addr_s;
  logic       oob_s;
  logic       corner_blk_s;

`ifdef DIAGONAL_EN
  // Wall results of N/E/S/W seen in this expansion, indexed by direction
  logic [3:0] orth_wall_r;
`endif

  nb_dir_decode u_dir_decode (
    .dir  (dir_r),
    .dx   (dx_s),
    .dy   (dy_s),
    .cost (cost_s),
    .diag (diag_s)
  );

  // Candidate coordinates, bounds test and wall bitmap address
  always_comb begin
    cand_x_s = cur_x_r + {{(COORD_W-2){dx_s[1]}}, dx_s};
    cand_y_s = cur_y_r + {{(COORD_W-2){dy_s[1]}}, dy_s};
    oob_s    = ((dx_s == 2'b11) && (cur_x_r == {COORD_W{1'b0}}))       ||
               ((dx_s == 2'b01) && (cur_x_r == coord_t'(GRID_W - 1)))  ||
               ((dy_s == 2'b11) && (cur_y_r == {COORD_W{1'b0}}))       ||
               ((dy_s == 2'b01) && (cur_y_r == coord_t'(GRID_H - 1)));
    addr_s   = addr_t'(cand_y_s) * addr_t'(GRID_W) + addr_t'(cand_x_s);
  end

  // Diagonal is blocked when either orthogonal cell it squeezes between is a wall
  always_comb begin
    corner_blk_s = 1'b0;
`ifdef DIAGONAL_EN
    case (dir_r)
      DIR_NE:  corner_blk_s = orth_wall_r[DIR_N] | orth_wall_r[DIR_E];
      DIR_SE:  corner_blk_s = orth_wall_r[DIR_S] | orth_wall_r[DIR_E];
      DIR_SW:  corner_blk_s = orth_wall_r[DIR_S] | orth_wall_r[DIR_W];
      DIR_NW:  corner_blk_s = orth_wall_r[DIR_N] | orth_wall_r[DIR_W];
      default: corner_blk_s = 1'b0;
    endcase
`else
    // No wall history is kept without diagonals; the flag only qualifies the term
    corner_blk_s = diag_s & 1'b0;
`endif
  end

`ifdef DIAGONAL_EN
  // Record orthogonal wall results; out-of-bounds orthogonals imply out-of-bounds diagonals
  always_ff @(posedge Clk) begin
    if (Reset) begin
      orth_wall_r <= 4'b0000;
    end else if (state_r == ST_IDLE && start) begin
      orth_wall_r <= 4'b0000;
    end else if (state_r == ST_WALL_CHK && !diag_s) begin
      orth_wall_r[dir_r[1:0]] <= wall_rd_data;
    end else begin
      orth_wall_r <= orth_wall_r;
    end
  end
`endif

  // Expansion FSM with all outputs registered
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_r    <= ST_IDLE;
      dir_r      <= DIR_N;
      cur_x_r    <= {COORD_W{1'b0}};
      cur_y_r    <= {COORD_W{1'b0}};
      cur_g_r    <= {G_W{1'b0}};
      wall_rd_en <= 1'b0;
      wall_addr  <= {ADDR_W{1'b0}};
      nb_valid   <= 1'b0;
      nb_x       <= {COORD_W{1'b0}};
      nb_y       <= {COORD_W{1'b0}};
      nb_g       <= {G_W{1'b0}};
      busy       <= 1'b0;
      done       <= 1'b0;
      nb_count   <= 4'd0;
    end else begin
      wall_rd_en <= 1'b0;
      done       <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            cur_x_r  <= cur_x;
            cur_y_r  <= cur_y;
            cur_g_r  <= cur_g;
            dir_r    <= DIR_N;
            busy     <= 1'b1;
            nb_count <= 4'd0;
            state_r  <= ST_SELECT;
          end else begin
            state_r  <= ST_IDLE;
          end
        end
        ST_SELECT: begin
          if (oob_s || corner_blk_s) begin
            state_r    <= ST_NEXT;
          end else begin
            wall_addr  <= addr_s;
            wall_rd_en <= 1'b1;
            state_r    <= ST_WALL_WAIT;
          end
        end
        ST_WALL_WAIT: begin
          state_r <= ST_WALL_CHK;
        end
        ST_WALL_CHK: begin
          if (wall_rd_data) begin
            state_r  <= ST_NEXT;
          end else begin
            nb_x     <= cand_x_s;
            nb_y     <= cand_y_s;
            nb_g     <= sat_add(cur_g_r, cost_s);
            nb_valid <= 1'b1;
            state_r  <= ST_EMIT;
          end
        end
        ST_EMIT: begin
          if (nb_ready) begin
            nb_valid <= 1'b0;
            nb_count <= nb_count + 4'd1;
            state_r  <= ST_NEXT;
          end else begin
            state_r  <= ST_EMIT;
          end
        end
        ST_NEXT: begin
          if (dir_r == LAST_DIR) begin
            done    <= 1'b1;
            state_r <= ST_DONE;
          end else begin
            dir_r   <= dir_t'(dir_r + 3'd1);
            state_r <= ST_SELECT;
          end
        end
        ST_DONE: begin
          busy    <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          nb_valid <= 1'b0;
          busy     <= 1'b0;
          state_r  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
